kronos_counter_bank: RTL and testbench

Parametrised machine counter bank for the Kronos core. It generalises the fixed mcycle/minstret pair into N event counters of configurable width, each with a per-counter inhibit bit and a one-cycle overflow pulse. It sits beside the CSR file and serves the counter CSR addresses (0xB00–0xB1F low halves, 0xB80–0xB9F high halves, mcountinhibit 0x320) over a registered request/response port.

---
 rtl/kronos_counter_bank.sv | 148 ++++++++++++++
 tb/tb_kronos_counter_bank.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : kronos_counter_bank
// Brief    : N machine event counters (mcycle/minstret/mhpmcounterN) with
//            inhibit, overflow pulse and a registered CSR request/response port.
// Revision : 1.0 - initial release
// ============================================================================
module kronos_counter_bank #(
    parameter int N_COUNTERS = 3,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_COUNTERS-1:0] event_inc,
    input  logic                  csr_req,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic                  csr_rvalid,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal,
    output logic [N_COUNTERS-1:0] ovf
);

    localparam logic [6:0]  C_LO_BASE      = 7'h58;   // 0xB00 >> 5
    localparam logic [6:0]  C_HI_BASE      = 7'h5C;   // 0xB80 >> 5
    localparam logic [11:0] C_INHIBIT_ADDR = 12'h320;

    logic [N_COUNTERS-1:0] r_inh;
    logic [WIDTH-1:0]      w_cnt [N_COUNTERS];

    logic [4:0]            w_idx;
    logic [4:0]            w_sel;
    logic                  w_sel_ok;
    logic                  w_is_lo;
    logic                  w_is_hi;
    logic                  w_is_inh;
    logic                  w_legal;
    logic                  w_wr;
    logic [WIDTH-1:0]      w_sel_val;
    logic [31:0]           w_inh_rd;
    logic [N_COUNTERS-1:0] w_inh_wr;
    logic [31:0]           w_rdata;

    // Index 1 is the time CSR, which lives elsewhere; every other index j>0
    // selects counter j-1.
    always_comb begin
        w_idx    = csr_addr[4:0];
        w_sel    = (w_idx == 5'd0) ? 5'd0 : (w_idx - 5'd1);
        w_sel_ok = (w_idx != 5'd1) && ({1'b0, w_sel} < 6'(N_COUNTERS));
        w_is_lo  = (csr_addr[11:5] == C_LO_BASE) && w_sel_ok;
        w_is_hi  = (csr_addr[11:5] == C_HI_BASE) && w_sel_ok;
        w_is_inh = (csr_addr == C_INHIBIT_ADDR);
        w_legal  = w_is_lo || w_is_hi || w_is_inh;
        w_wr     = csr_req && csr_we;
    end

    always_comb begin
        w_sel_val = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (w_sel == 5'(k)) begin
                w_sel_val = w_cnt[k];
            end
        end
    end

    // mcountinhibit layout mirrors the counter address map (bit 1 is time).
    always_comb begin
        w_inh_rd    = '0;
        w_inh_rd[0] = r_inh[0];
        w_inh_wr    = r_inh;
        w_inh_wr[0] = csr_wdata[0];
        for (int k = 1; k < N_COUNTERS; k++) begin
            if (k < 31) begin
                w_inh_rd[k+1] = r_inh[k];
                w_inh_wr[k]   = csr_wdata[k+1];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_inh) begin
            w_rdata = w_inh_rd;
        end else if (w_is_lo) begin
            w_rdata = w_sel_val[31:0];
        end else if (w_is_hi) begin
            w_rdata = 32'(w_sel_val[WIDTH-1:32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_rvalid  <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
        end else begin
            csr_rvalid  <= csr_req;
            csr_rdata   <= csr_req ? w_rdata : 32'h0;
            csr_illegal <= csr_req && !w_legal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inh <= '0;
        end else if (w_wr && w_is_inh) begin
            r_inh <= w_inh_wr;
        end
    end

    for (genvar k = 0; k < N_COUNTERS; k++) begin : g_cnt
        logic [WIDTH-1:0] r_val;
        logic             r_ovf;
        logic             w_hit;
        logic             w_inc;
        logic [WIDTH-1:0] w_lo_val;
        logic [WIDTH-1:0] w_hi_val;

        assign w_hit    = w_wr && (w_sel == 5'(k));
        assign w_inc    = event_inc[k] && !r_inh[k];
        assign w_lo_val = {r_val[WIDTH-1:32], csr_wdata};
        assign w_hi_val = {csr_wdata[WIDTH-33:0], r_val[31:0]};

        // A CSR write to this counter replaces the increment and never wraps.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_val <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= 1'b0;
                if (w_hit && w_is_lo) begin
                    r_val <= w_lo_val;
                end else if (w_hit && w_is_hi) begin
                    r_val <= w_hi_val;
                end else if (w_inc) begin
                    r_val <= r_val + WIDTH'(1);
                    r_ovf <= &r_val;
                end
            end
        end

        assign w_cnt[k] = r_val;
        assign ovf[k]   = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_kronos_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_kronos_counter_bank
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a behavioural model, on 64- and 40-bit DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kronos_counter_bank;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  event_inc = '0;
    logic          csr_req = 1'b0;
    logic          csr_we = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [31:0]   csr_wdata = '0;

    logic          a_rvalid, a_illegal, b_rvalid, b_illegal;
    logic [31:0]   a_rdata, b_rdata;
    logic [N-1:0]  a_ovf, b_ovf;

    kronos_counter_bank #(.N_COUNTERS(N), .WIDTH(64)) u_dut_w64 (
        .clk(clk), .rst(rst), .event_inc(event_inc), .csr_req(csr_req),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rvalid(a_rvalid), .csr_rdata(a_rdata), .csr_illegal(a_illegal),
        .ovf(a_ovf)
    );

    kronos_counter_bank #(.N_COUNTERS(N), .WIDTH(40)) u_dut_w40 (
        .clk(clk), .rst(rst), .event_inc(event_inc), .csr_req(csr_req),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rvalid(b_rvalid), .csr_rdata(b_rdata), .csr_illegal(b_illegal),
        .ovf(b_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one counter array per DUT width.
    int           widths [2] = '{64, 40};
    logic [63:0]  m_cnt [2][N];
    logic [N-1:0] m_inh [2];
    logic         e_rvalid [2];
    logic [31:0]  e_rdata [2];
    logic         e_ill [2];
    logic [N-1:0] e_ovf [2];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [2:0]  inc;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        if (w >= 64) return {64{1'b1}};
        return (64'd1 << w) - 64'd1;
    endfunction

    // kind: 0 illegal, 1 low half, 2 high half, 3 mcountinhibit
    function automatic void decode(input logic [11:0] a, output int kind, output int c);
        int j;
        kind = 0;
        c    = 0;
        j    = int'(a[4:0]);
        if (a == 12'h320) begin
            kind = 3;
        end else if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
            c = (j == 0) ? 0 : j - 1;
            if (j != 1 && c < N) kind = (a < 12'hB80) ? 1 : 2;
        end
    endfunction

    function automatic logic [31:0] inh_pack(input logic [N-1:0] inh);
        logic [31:0] r;
        r    = '0;
        r[0] = inh[0];
        for (int k = 1; k < N; k++) r[k+1] = inh[k];
        return r;
    endfunction

    function automatic logic [N-1:0] inh_unpack(input logic [31:0] w);
        logic [N-1:0] u;
        u[0] = w[0];
        for (int k = 1; k < N; k++) u[k] = w[k+1];
        return u;
    endfunction

    task automatic model_step();
        int           kind, c;
        logic [N-1:0] old_inh;
        logic [63:0]  mask, nv;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < N; k++) m_cnt[d][k] = '0;
                m_inh[d] = '0; e_rvalid[d] = 1'b0; e_rdata[d] = '0;
                e_ill[d] = 1'b0; e_ovf[d] = '0;
            end else begin
                decode(csr_addr, kind, c);
                e_rvalid[d] = csr_req;
                e_rdata[d]  = '0;
                e_ill[d]    = 1'b0;
                if (csr_req) begin
                    case (kind)
                        0: e_ill[d] = 1'b1;
                        1: e_rdata[d] = m_cnt[d][c][31:0];
                        2: e_rdata[d] = m_cnt[d][c][63:32];
                        default: e_rdata[d] = inh_pack(m_inh[d]);
                    endcase
                end
                old_inh  = m_inh[d];
                mask     = wmask(widths[d]);
                e_ovf[d] = '0;
                for (int k = 0; k < N; k++) begin
                    if (csr_req && csr_we && (kind == 1 || kind == 2) && c == k) begin
                        if (kind == 1)
                            m_cnt[d][k] = (m_cnt[d][k] & 64'hFFFF_FFFF_0000_0000) | {32'h0, csr_wdata};
                        else
                            m_cnt[d][k] = ({csr_wdata, 32'h0} | (m_cnt[d][k] & 64'hFFFF_FFFF)) & mask;
                    end else if (event_inc[k] && !old_inh[k]) begin
                        nv = (m_cnt[d][k] + 64'd1) & mask;
                        if (nv == 64'd0) e_ovf[d][k] = 1'b1;
                        m_cnt[d][k] = nv;
                    end
                end
                if (csr_req && csr_we && kind == 3) m_inh[d] = inh_unpack(csr_wdata);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("sb_rvalid_w64",  a_rvalid,  e_rvalid[0]);
        chk("sb_rdata_w64",   a_rdata,   e_rdata[0]);
        chk("sb_illegal_w64", a_illegal, e_ill[0]);
        chk("sb_ovf_w64",     a_ovf,     e_ovf[0]);
        chk("sb_rvalid_w40",  b_rvalid,  e_rvalid[1]);
        chk("sb_rdata_w40",   b_rdata,   e_rdata[1]);
        chk("sb_illegal_w40", b_illegal, e_ill[1]);
        chk("sb_ovf_w40",     b_ovf,     e_ovf[1]);
    endtask

    task automatic drive(input logic req, input logic we, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [N-1:0] inc);
        csr_req = req; csr_we = we; csr_addr = addr; csr_wdata = wdata; event_inc = inc;
    endtask

    logic [11:0] alist [12] = '{12'hB00, 12'hB02, 12'hB03, 12'hB80, 12'hB82, 12'hB83,
                                12'h320, 12'hB01, 12'hB04, 12'h7C0, 12'hB1F, 12'hB9F};

    initial begin
        logic [63:0] v;
        logic [31:0] wd;

        tbl[0]  = '{1'b1, 12'hB00, 32'h1234,      3'b001, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 12'hB00, 32'h0,         3'b001, 32'h1234,      1'b0};
        tbl[2]  = '{1'b1, 12'hB00, 32'hFFFF_FFFF, 3'b001, 32'h1235,      1'b0};
        tbl[3]  = '{1'b0, 12'hB00, 32'h0,         3'b000, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{1'b0, 12'hB80, 32'h0,         3'b001, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 12'hB80, 32'h0,         3'b000, 32'h1,         1'b0};
        tbl[6]  = '{1'b0, 12'hB00, 32'h0,         3'b000, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 12'hB01, 32'h0,         3'b000, 32'h0,         1'b1};
        tbl[8]  = '{1'b0, 12'hB04, 32'h0,         3'b000, 32'h0,         1'b1};
        tbl[9]  = '{1'b0, 12'h7C0, 32'h0,         3'b000, 32'h0,         1'b1};
        tbl[10] = '{1'b1, 12'hB01, 32'h5,         3'b000, 32'h0,         1'b1};
        tbl[11] = '{1'b1, 12'h320, 32'h5,         3'b111, 32'h0,         1'b0};
        tbl[12] = '{1'b0, 12'h320, 32'h0,         3'b111, 32'h5,         1'b0};
        tbl[13] = '{1'b0, 12'hB02, 32'h0,         3'b111, 32'h1,         1'b0};
        tbl[14] = '{1'b0, 12'hB03, 32'h0,         3'b111, 32'h3,         1'b0};
        tbl[15] = '{1'b0, 12'hB00, 32'h0,         3'b000, 32'h1,         1'b0};
        tbl[16] = '{1'b1, 12'h320, 32'h0,         3'b000, 32'h5,         1'b0};
        tbl[17] = '{1'b1, 12'hB83, 32'hABCD,      3'b100, 32'h0,         1'b0};
        tbl[18] = '{1'b0, 12'hB83, 32'h0,         3'b000, 32'hABCD,      1'b0};
        tbl[19] = '{1'b0, 12'hB03, 32'h0,         3'b000, 32'h4,         1'b0};
        tbl[20] = '{1'b0, 12'hB82, 32'h0,         3'b000, 32'h0,         1'b0};
        tbl[21] = '{1'b0, 12'hB9F, 32'h0,         3'b000, 32'h0,         1'b1};
        tbl[22] = '{1'b1, 12'hB80, 32'h22,        3'b001, 32'h1,         1'b0};
        tbl[23] = '{1'b0, 12'hB80, 32'h0,         3'b000, 32'h22,        1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_rvalid", a_rvalid, 1'b0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_illegal", a_illegal, 1'b0);
        chk("rst_ovf", a_ovf, 3'b000);
        rst = 1'b0;
        tick();

        // Directed vector table (expectations for the 64-bit instance)
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].inc);
            tick();
            chk($sformatf("tbl%0d_rvalid", i), a_rvalid, 1'b1);
            chk($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_illegal", i), a_illegal, tbl[i].exp_ill);
        end
        drive(1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
        tick();

        // Carry and overflow on counter 1
        drive(1'b1, 1'b1, 12'hB82, 32'hFFFF_FFFF, 3'b000); tick();
        drive(1'b1, 1'b1, 12'hB02, 32'hFFFF_FFFF, 3'b000); tick();
        drive(1'b1, 1'b0, 12'hB82, 32'h0, 3'b000); tick();
        chk("prewrap_hi_w64", a_rdata, 32'hFFFF_FFFF);
        chk("prewrap_hi_w40", b_rdata, 32'hFF);
        drive(1'b0, 1'b0, 12'h0, 32'h0, 3'b010); tick();
        chk("wrap_ovf_w64", a_ovf, 3'b010);
        chk("wrap_ovf_w40", b_ovf, 3'b010);
        drive(1'b0, 1'b0, 12'h0, 32'h0, 3'b000); tick();
        chk("ovf_pulse_w64", a_ovf, 3'b000);
        chk("ovf_pulse_w40", b_ovf, 3'b000);
        drive(1'b1, 1'b0, 12'hB82, 32'h0, 3'b000); tick();
        chk("postwrap_hi_w64", a_rdata, 32'h0);
        chk("postwrap_hi_w40", b_rdata, 32'h0);
        drive(1'b1, 1'b0, 12'hB02, 32'h0, 3'b000); tick();
        chk("postwrap_lo_w64", a_rdata, 32'h0);

        // Write coincident with wrap: write wins, no overflow
        drive(1'b1, 1'b1, 12'hB82, 32'hFFFF_FFFF, 3'b000); tick();
        drive(1'b1, 1'b1, 12'hB02, 32'hFFFF_FFFF, 3'b000); tick();
        drive(1'b1, 1'b1, 12'hB02, 32'h7, 3'b010); tick();
        chk("wrwrap_old", a_rdata, 32'hFFFF_FFFF);
        chk("wrwrap_ovf_w64", a_ovf, 3'b000);
        chk("wrwrap_ovf_w40", b_ovf, 3'b000);
        drive(1'b1, 1'b0, 12'hB02, 32'h0, 3'b000); tick();
        chk("wrwrap_val", a_rdata, 32'h7);
        drive(1'b1, 1'b0, 12'hB82, 32'h0, 3'b000); tick();
        chk("wrwrap_hi_w40", b_rdata, 32'hFF);

        // Back-to-back low/high reads across a carry
        drive(1'b1, 1'b1, 12'hB00, 32'hFFFF_FFFF, 3'b000); tick();
        v = m_cnt[0][0];
        drive(1'b1, 1'b0, 12'hB00, 32'h0, 3'b001); tick();
        chk("bb_rvalid0", a_rvalid, 1'b1);
        chk("bb_lo", a_rdata, v[31:0]);
        v = v + 64'd1;
        drive(1'b1, 1'b0, 12'hB80, 32'h0, 3'b001); tick();
        chk("bb_rvalid1", a_rvalid, 1'b1);
        chk("bb_hi", a_rdata, v[63:32]);

        // Asynchronous reset mid-run with a request in flight
        drive(1'b1, 1'b0, 12'hB00, 32'h0, 3'b001); tick();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", a_rvalid, 1'b0);
        chk("async_rst_rdata", a_rdata, 32'h0);
        chk("async_rst_rvalid_w40", b_rvalid, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 12'h0, 32'h0, 3'b001);
        repeat (10) tick();
        drive(1'b1, 1'b0, 12'hB00, 32'h0, 3'b001); tick();
        chk("count10_w64", a_rdata, 32'd10);
        chk("count10_w40", b_rdata, 32'd10);
        drive(1'b1, 1'b0, 12'hB02, 32'h0, 3'b000); tick();
        chk("count10_minstret", a_rdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  alist[$urandom_range(0, 11)], wd, 3'($urandom_range(0, 7)));
            tick();
        end
        drive(1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
